// File: rtl/fme_mv_ram_wr_ctrl_pkg.sv
// Shared encoder constants used by the MV RAM write controller.
// This package stands in for the FMV_WIDTH definition in enc_defines.v.
package fme_mv_ram_wr_ctrl_pkg;

    localparam int ENC_FMV_WIDTH     = 10;
    localparam int MV_RAM_ADDR_WIDTH = 6;

endpackage

// File: rtl/fme_mv_ram_wr_ctrl.sv
// Write controller for port B of the 64-entry MV RAM: takes a burst of MV
// beats over a valid/ready handshake and turns them into registered RAM writes.
module fme_mv_ram_wr_ctrl
    import fme_mv_ram_wr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = MV_RAM_ADDR_WIDTH,
    parameter int FMV_WIDTH  = ENC_FMV_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  base_addr_i,
    input  logic [ADDR_WIDTH:0]    num_i,
    input  logic                   mv_valid_i,
    input  logic [FMV_WIDTH-1:0]   mv_x_i,
    input  logic [FMV_WIDTH-1:0]   mv_y_i,
    output logic                   mv_ready_o,
    output logic                   cenb_o,
    output logic                   wenb_o,
    output logic [ADDR_WIDTH-1:0]  addrb_o,
    output logic [2*FMV_WIDTH-1:0] datab_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH:0]   cnt_next;
    logic [ADDR_WIDTH:0]   num_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  accept;

    // Ready depends only on state and beat count so upstream can never loop valid into it.
    assign mv_ready_o = (state_q == WRITE) && (cnt_q < num_q);
    assign accept     = mv_valid_i && mv_ready_o;
    assign cnt_next   = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_i == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (accept && (cnt_next == num_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address wraps naturally modulo the RAM depth through the ADDR_WIDTH-bit add.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            base_q  <= '0;
            cenb_o  <= 1'b1;
            wenb_o  <= 1'b1;
            addrb_o <= '0;
            datab_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != IDLE);
            done_o  <= (state_q == DONE);
            err_o   <= start_i && (state_q != IDLE);
            cenb_o  <= ~accept;
            wenb_o  <= ~accept;
            if ((state_q == IDLE) && start_i) begin
                base_q <= base_addr_i;
                num_q  <= num_i;
                cnt_q  <= '0;
            end else if (accept) begin
                cnt_q <= cnt_next;
            end
            if (accept) begin
                addrb_o <= base_q + cnt_q[ADDR_WIDTH-1:0];
                datab_o <= {mv_x_i, mv_y_i};
            end
        end
    end

endmodule

// File: tb/tb_fme_mv_ram_wr_ctrl.sv
// Self-checking bench for fme_mv_ram_wr_ctrl: burst-level reference model in
// lockstep with the DUT, a scenario table, directed corner cases and random bursts.
module tb_fme_mv_ram_wr_ctrl;

    localparam int AW = 6;
    localparam int FW = 10;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW:0]   num_i;
    logic          mv_valid_i;
    logic [FW-1:0] mv_x_i;
    logic [FW-1:0] mv_y_i;
    logic          mv_ready_o;
    logic          cenb_o;
    logic          wenb_o;
    logic [AW-1:0] addrb_o;
    logic [2*FW-1:0] datab_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    fme_mv_ram_wr_ctrl #(.ADDR_WIDTH(AW), .FMV_WIDTH(FW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .num_i      (num_i),
        .mv_valid_i (mv_valid_i),
        .mv_x_i     (mv_x_i),
        .mv_y_i     (mv_y_i),
        .mv_ready_o (mv_ready_o),
        .cenb_o     (cenb_o),
        .wenb_o     (wenb_o),
        .addrb_o    (addrb_o),
        .datab_o    (datab_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Burst-level reference: a burst is open from start until done, beats counted as integers.
    bit          m_open = 1'b0;
    bit          m_fin = 1'b0;
    int          m_num = 0;
    int          m_base = 0;
    int          m_acc = 0;
    logic        exp_cen = 1'b1;
    logic [AW-1:0] exp_addr = '0;
    logic [2*FW-1:0] exp_data = '0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;

    int wr_count, done_count, err_count, busy_count;
    int first_wr_cyc, last_wr_cyc, done_cyc, start_cyc;
    logic [AW-1:0]   addr_q[$];
    logic [2*FW-1:0] data_q[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelStep();
        bit open_pre, fin_pre, ready, acc;
        cyc++;
        if (rst) begin
            m_open = 0; m_fin = 0; m_num = 0; m_base = 0; m_acc = 0;
            exp_cen = 1'b1; exp_addr = '0; exp_data = '0; exp_done = 1'b0; exp_err = 1'b0;
            return;
        end
        open_pre = m_open;
        fin_pre  = m_fin;
        ready    = m_open && (m_acc < m_num);
        acc      = mv_valid_i && ready;
        exp_err  = start_i && open_pre;
        exp_done = 1'b0;
        exp_cen  = ~acc;
        if (acc) begin
            exp_addr = AW'((m_base + m_acc) % 64);
            exp_data = {mv_x_i, mv_y_i};
            m_acc++;
            if (m_acc == m_num) m_fin = 1;
        end
        if (fin_pre) begin
            exp_done = 1'b1;
            m_open = 0;
            m_fin = 0;
        end
        if (start_i && !open_pre) begin
            m_open = 1;
            m_base = int'(base_addr_i);
            m_num  = int'(num_i);
            m_acc  = 0;
            m_fin  = (m_num == 0);
        end
    endtask

    always @(posedge clk) modelStep();

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cenb", 32'(cenb_o), 32'(exp_cen));
            checkOutput("wenb", 32'(wenb_o), 32'(exp_cen));
            checkOutput("addrb", 32'(addrb_o), 32'(exp_addr));
            checkOutput("datab", 32'(datab_o), 32'(exp_data));
            checkOutput("busy", 32'(busy_o), 32'(m_open));
            checkOutput("done", 32'(done_o), 32'(exp_done));
            checkOutput("err", 32'(err_o), 32'(exp_err));
            checkOutput("ready", 32'(mv_ready_o), 32'(m_open && (m_acc < m_num)));
            if (cenb_o == 1'b0) begin
                if (wr_count == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_count++;
                addr_q.push_back(addrb_o);
                data_q.push_back(datab_o);
            end
            if (done_o) begin
                done_count++;
                done_cyc = cyc;
            end
            if (busy_o) busy_count++;
            if (err_o) err_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        wr_count = 0; done_count = 0; err_count = 0; busy_count = 0;
        first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
        addr_q.delete();
        data_q.delete();
    endtask

    // Runs one burst; err_at injects a stray start on that beat cycle, rst_after resets after that many beats.
    task automatic applyStimulus(input logic [AW-1:0] base, input int num, input int gap_pct,
                                 input bit fixed, input logic [FW-1:0] fx, input logic [FW-1:0] fy,
                                 input int err_at, input int rst_after);
        bit finished = 0;
        clearLog();
        start_i = 1'b1;
        base_addr_i = base;
        num_i = (AW+1)'(num);
        mv_valid_i = 1'b0;
        start_cyc = cyc;
        tick();
        start_i = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!m_open) begin
                finished = 1;
                break;
            end
            if (rst_after > 0 && m_acc == rst_after) begin
                mv_valid_i = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                finished = 1;
                break;
            end
            mv_valid_i = ($urandom_range(99) >= gap_pct);
            mv_x_i = fixed ? fx : FW'($urandom);
            mv_y_i = fixed ? fy : FW'($urandom);
            if (c == err_at) begin
                start_i = 1'b1;
                base_addr_i = AW'($urandom);
                num_i = (AW+1)'($urandom_range(64));
            end else begin
                start_i = 1'b0;
            end
            tick();
        end
        start_i = 1'b0;
        mv_valid_i = 1'b0;
        if (!finished) checkOutput("burst_timeout", 32'd1, 32'd0);
        tick();
        tick();
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            num;
        int            gap_pct;
        int            exp_writes;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{base: 6'd0,  num: 4,  gap_pct: 0,  exp_writes: 4,  exp_first: 6'd0,  exp_last: 6'd3};
        vecs[1] = '{base: 6'd62, num: 4,  gap_pct: 0,  exp_writes: 4,  exp_first: 6'd62, exp_last: 6'd1};
        vecs[2] = '{base: 6'd10, num: 1,  gap_pct: 30, exp_writes: 1,  exp_first: 6'd10, exp_last: 6'd10};
        vecs[3] = '{base: 6'd63, num: 64, gap_pct: 20, exp_writes: 64, exp_first: 6'd63, exp_last: 6'd62};
        vecs[4] = '{base: 6'd5,  num: 7,  gap_pct: 50, exp_writes: 7,  exp_first: 6'd5,  exp_last: 6'd11};
        vecs[5] = '{base: 6'd33, num: 2,  gap_pct: 0,  exp_writes: 2,  exp_first: 6'd33, exp_last: 6'd34};

        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; num_i = '0;
        mv_valid_i = 1'b0; mv_x_i = '0; mv_y_i = '0;
        clearLog();
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("reset_cenb", 32'(cenb_o), 32'd1);
        checkOutput("reset_addrb", 32'(addrb_o), 32'd0);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_ready", 32'(mv_ready_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        $display("[TB] contiguous burst base=0 num=4");
        applyStimulus(6'd0, 4, 0, 0, '0, '0, -1, -1);
        checkOutput("b0_writes", 32'(wr_count), 32'd4);
        checkOutput("b0_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd3);
        checkOutput("b0_done_after_last", 32'(done_cyc - last_wr_cyc), 32'd1);
        checkOutput("b0_last_addr", 32'(addr_q[$]), 32'd3);

        $display("[TB] wrap burst base=62 num=4 fixed data");
        applyStimulus(6'd62, 4, 0, 1, 10'h3FF, 10'h001, -1, -1);
        checkOutput("wrap_writes", 32'(wr_count), 32'd4);
        if (wr_count == 4) begin
            checkOutput("wrap_a0", 32'(addr_q[0]), 32'd62);
            checkOutput("wrap_a1", 32'(addr_q[1]), 32'd63);
            checkOutput("wrap_a2", 32'(addr_q[2]), 32'd0);
            checkOutput("wrap_a3", 32'(addr_q[3]), 32'd1);
            checkOutput("wrap_data", 32'(data_q[0]), 32'hFFC01);
        end

        $display("[TB] empty burst num=0");
        applyStimulus(6'd9, 0, 0, 0, '0, '0, -1, -1);
        checkOutput("zero_writes", 32'(wr_count), 32'd0);
        checkOutput("zero_done_delay", 32'(done_cyc - start_cyc), 32'd2);
        checkOutput("zero_busy_len", 32'(busy_count), 32'd1);

        $display("[TB] gapped burst num=3");
        clearLog();
        start_i = 1'b1; base_addr_i = 6'd20; num_i = 7'd3;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mv_valid_i = (i == 0 || i == 3 || i >= 6);
            mv_x_i = FW'(i); mv_y_i = FW'(i + 1);
            tick();
        end
        mv_valid_i = 1'b0;
        tick();
        checkOutput("gap_writes", 32'(wr_count), 32'd3);
        checkOutput("gap_span", 32'(last_wr_cyc - first_wr_cyc), 32'd6);
        checkOutput("gap_done", 32'(done_count), 32'd1);

        $display("[TB] stray start during write");
        applyStimulus(6'd20, 5, 30, 0, '0, '0, 2, -1);
        checkOutput("err_pulses", 32'(err_count), 32'd1);
        checkOutput("err_writes", 32'(wr_count), 32'd5);
        checkOutput("err_last_addr", 32'(addr_q[$]), 32'd24);

        $display("[TB] reset after 2 of 5 beats");
        applyStimulus(6'd40, 5, 0, 0, '0, '0, -1, 2);
        repeat (4) tick();
        checkOutput("rst_writes", 32'(wr_count), 32'd2);
        checkOutput("rst_no_done", 32'(done_count), 32'd0);
        applyStimulus(6'd7, 3, 0, 0, '0, '0, -1, -1);
        checkOutput("post_rst_writes", 32'(wr_count), 32'd3);
        checkOutput("post_rst_done", 32'(done_count), 32'd1);
        checkOutput("post_rst_first", 32'(addr_q[0]), 32'd7);

        $display("[TB] scenario table");
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].base, vecs[v].num, vecs[v].gap_pct, 0, '0, '0, -1, -1);
            checkOutput($sformatf("vec%0d_writes", v), 32'(wr_count), 32'(vecs[v].exp_writes));
            checkOutput($sformatf("vec%0d_done", v), 32'(done_count), 32'd1);
            if (wr_count > 0) begin
                checkOutput($sformatf("vec%0d_first", v), 32'(addr_q[0]), 32'(vecs[v].exp_first));
                checkOutput($sformatf("vec%0d_last", v), 32'(addr_q[$]), 32'(vecs[v].exp_last));
            end
        end

        $display("[TB] random bursts");
        for (int r = 0; r < 20; r++) begin
            int num, err_at, rst_after;
            num = $urandom_range(64);
            err_at = ($urandom_range(3) == 0) ? $urandom_range(num + 1) : -1;
            rst_after = ($urandom_range(5) == 0 && num > 1) ? $urandom_range(num - 1, 1) : -1;
            applyStimulus(AW'($urandom), num, $urandom_range(60), 0, '0, '0, err_at, rst_after);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fme_mv_ram_wr_ctrl.md
FME_MV_RAM_WR_CTRL -- requirements
Module: fme_mv_ram_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, giving the MV RAM address width (64 entries).
REQ-002 SHALL have parameter FMV_WIDTH, default `FMV_WIDTH from enc_defines.v, giving the per-component MV width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle pulse that begins a write burst.
REQ-006 SHALL have port base_addr_i  input  ADDR_WIDTH  first RAM address of the burst, sampled on start_i.
REQ-007 SHALL have port num_i  input  ADDR_WIDTH+1  MV count of the burst (0..64), sampled on start_i.
REQ-008 SHALL have port mv_valid_i  input  1  MV beat valid.
REQ-009 SHALL have port mv_x_i  input  FMV_WIDTH  horizontal MV component.
REQ-010 SHALL have port mv_y_i  input  FMV_WIDTH  vertical MV component.
REQ-011 SHALL have port mv_ready_o  output  1  MV beat ready.
REQ-012 SHALL have port cenb_o  output  1  RAM write-port chip enable, low active.
REQ-013 SHALL have port wenb_o  output  1  RAM write-port write enable, low active.
REQ-014 SHALL have port addrb_o  output  ADDR_WIDTH  RAM write address.
REQ-015 SHALL have port datab_o  output  2*FMV_WIDTH  RAM write data.
REQ-016 SHALL have port busy_o  output  1  high while a burst is in progress.
REQ-017 SHALL have port done_o  output  1  one-cycle pulse marking burst completion.
REQ-018 SHALL have port err_o  output  1  one-cycle pulse marking a start_i that was ignored.

Function
REQ-019 SHALL implement the FSM states IDLE, WRITE and DONE.
REQ-020 In IDLE, start_i SHALL latch base_addr_i and num_i and move to WRITE; if num_i==0 it SHALL move to DONE instead.
REQ-021 A beat SHALL be accepted only on a cycle where mv_valid_i and mv_ready_o are both high.
REQ-022 mv_ready_o SHALL be high only in WRITE while the accepted-beat count is below the latched num.
REQ-023 For each accepted beat, the cycle after acceptance SHALL show cenb_o=0, wenb_o=0, addrb_o=(base+index) mod 64 and datab_o={mv_x_i, mv_y_i}, with x in the MSBs.
REQ-024 On every cycle with no write, cenb_o and wenb_o SHALL be 1, and addrb_o/datab_o SHALL hold their last values.
REQ-025 The address SHALL wrap from 63 to 0 with no error indication.
REQ-026 After the last beat is accepted, the FSM SHALL go to DONE; done_o SHALL pulse in the cycle after the last RAM write (or the cycle after start for num=0), and the FSM SHALL then return to IDLE.
REQ-027 busy_o SHALL be high in WRITE and DONE.
REQ-028 start_i while not in IDLE SHALL be ignored and SHALL pulse err_o on the next cycle; the current burst SHALL be unaffected.
REQ-029 The block SHALL accept back-to-back beats at one per cycle, and mv_valid_i gaps SHALL insert idle RAM cycles only.
REQ-030 All outputs except mv_ready_o SHALL be registered; mv_ready_o SHALL be decoded from state and counter only, never from mv_valid_i.

Reset
REQ-031 rst SHALL force the FSM to IDLE, clear the counter, and set cenb_o=1, wenb_o=1, addrb_o=0, datab_o=0, mv_ready_o=0, busy_o=0, done_o=0 and err_o=0.
REQ-032 rst asserted mid-burst SHALL abandon the burst with no further RAM writes and no done_o pulse.

Structure
REQ-033 FMV_WIDTH SHALL come from the shared enc_defines.v; the FSM state encodings SHALL be local to the module.
REQ-034 The block SHALL be a single module with no sub-modules; it connects directly to port B of fme_mv_ram_dp_64x20.

Verification
REQ-035 Test: base=0, num=4, beats contiguous -> writes to addresses 0,1,2,3 on consecutive cycles, done_o one cycle after the address-3 write.
REQ-036 Test: base=62, num=4 -> writes to addresses 62,63,0,1; datab_o for x=10'h3FF, y=10'h001 equals 20'hFFC01.
REQ-037 Test: num=0 -> no cenb_o low, done_o exactly 2 cycles after start_i, busy_o high for 1 cycle.
REQ-038 Test: num=3, valid deasserted for 2 cycles between beats -> 3 writes total, cenb_o high during the gaps, mv_ready_o low after the 3rd beat.
REQ-039 Test: start_i during WRITE -> err_o pulse, original burst completes with the original count and addresses.
REQ-040 Test: rst after 2 of 5 beats -> cenb_o=1 from the next cycle, no done_o, a fresh start_i operates normally.
